// File: rtl/qft_sampler_core_pkg.sv
// Shared types, constants and helpers for the 2-qubit QFT sampler datapath.
// Provides state-vector slicing, signed 8-bit saturation and the e^x knot table.
package qft_sampler_core_pkg;

    localparam int TOTAL_BITS  = 8;
    localparam int FX_BITS     = 5;
    localparam int COMP_BITS   = 16;
    localparam int QSTATE_BITS = 64;

    // e^x sampled at x = -2.0, -1.5, ... , 2.0 in S2.5 units, unsigned.
    localparam logic [9:0] EXP_KNOTS [0:8] = '{
        10'd4, 10'd7, 10'd12, 10'd19, 10'd32,
        10'd53, 10'd87, 10'd143, 10'd236
    };

    // Amplitude n of a packed state; n = 0 is |00> in the top 16 bits.
    function automatic logic [COMP_BITS-1:0] amp(
        input logic [QSTATE_BITS-1:0] s,
        input int                     n
    );
        logic [QSTATE_BITS-1:0] t;
        t = s >> (COMP_BITS * (3 - n));
        return t[COMP_BITS-1:0];
    endfunction

    function automatic logic signed [TOTAL_BITS-1:0] amp_re(
        input logic [COMP_BITS-1:0] a
    );
        return a[15:8];
    endfunction

    function automatic logic signed [TOTAL_BITS-1:0] amp_im(
        input logic [COMP_BITS-1:0] a
    );
        return a[7:0];
    endfunction

    // Clamp to the signed 8-bit range; callers widen their operand to 18 bits.
    function automatic logic signed [TOTAL_BITS-1:0] sat8(
        input logic signed [17:0] v
    );
        if (v > 18'sd127)
            return 8'sd127;
        else if (v < -18'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/qft_sampler_core_exp_pwl8.sv
// Combinational 8-segment piecewise-linear e^x over [-2, 2), S2.5 in and out.
// Ports: x (signed S2.5 input), y (saturated S2.5 result, never negative).
import qft_sampler_core_pkg::*;

module exp_pwl8 (
    input  logic signed [TOTAL_BITS-1:0] x,
    output logic signed [TOTAL_BITS-1:0] y
);

    logic [7:0]  biased;
    logic [3:0]  kb;
    logic [3:0]  kn;
    logic [3:0]  off;
    logic [9:0]  b0;
    logic [9:0]  diff;
    logic [13:0] prod;
    logic [10:0] lin;

    always_comb begin
        // Shift x into [0, 127]: upper 3 bits pick the segment, low 4 the offset.
        biased = x + 8'd64;
        kb     = {1'b0, biased[6:4]};
        kn     = kb + 4'd1;
        off    = biased[3:0];
        b0     = EXP_KNOTS[kb];
        diff   = EXP_KNOTS[kn] - b0;
        prod   = {4'b0, diff} * {10'b0, off};
        lin    = {1'b0, b0} + {1'b0, prod[13:4]};

        if (x[7] && !x[6])
            y = '0;
        else if (!x[7] && x[6])
            y = 8'sd127;
        else
            y = sat8($signed({7'b0, lin}));
    end

endmodule

// File: rtl/qft_sampler_core.sv
// Registered e^x, 2-qubit QFT and |amp|^2 sampler paths for the QFT demo.
// Ports: clk, rst (sync, active high), in_valid, exp_x_in, q_state_in, samp_sel,
// samp_state_in -> exp_x_out, qft_state_out, mag_sq_out, out_valid.
import qft_sampler_core_pkg::*;

module qft_sampler_core (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [TOTAL_BITS-1:0]  exp_x_in,
    input  logic [QSTATE_BITS-1:0] q_state_in,
    input  logic                   samp_sel,
    input  logic [QSTATE_BITS-1:0] samp_state_in,
    output logic [TOTAL_BITS-1:0]  exp_x_out,
    output logic [QSTATE_BITS-1:0] qft_state_out,
    output logic [31:0]            mag_sq_out,
    output logic                   out_valid
);

    logic signed [TOTAL_BITS-1:0] exp_y;
    logic [QSTATE_BITS-1:0]       qft_next;
    logic [31:0]                  mag_next;
    logic [QSTATE_BITS-1:0]       samp_src;

    logic signed [9:0] xr [4];
    logic signed [9:0] xi [4];
    logic signed [9:0] sr [4];
    logic signed [9:0] si [4];

    logic signed [TOTAL_BITS-1:0] mr [4];
    logic signed [TOTAL_BITS-1:0] mi [4];
    logic signed [15:0]           rr [4];
    logic signed [15:0]           ii [4];
    logic [16:0]                  msum [4];
    logic [16:0]                  mshift [4];
    logic [7:0]                   m [4];

    // Floor-halve a 10-bit sum, then clamp to 8 bits.
    function automatic logic signed [TOTAL_BITS-1:0] half_sat(
        input logic signed [9:0] v
    );
        logic signed [9:0] h;
        h = v >>> 1;
        return sat8({{8{h[9]}}, h});
    endfunction

    exp_pwl8 u_exp (
        .x (exp_x_in),
        .y (exp_y)
    );

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            xr[j] = 10'(amp_re(amp(q_state_in, j)));
            xi[j] = 10'(amp_im(amp(q_state_in, j)));
        end

        // Multiplying by i maps (re, im) to (-im, re), so each output
        // is a signed sum of re/im-swapped inputs.
        sr[0] = xr[0] + xr[1] + xr[2] + xr[3];
        si[0] = xi[0] + xi[1] + xi[2] + xi[3];
        sr[1] = xr[0] - xi[1] - xr[2] + xi[3];
        si[1] = xi[0] + xr[1] - xi[2] - xr[3];
        sr[2] = xr[0] - xr[1] + xr[2] - xr[3];
        si[2] = xi[0] - xi[1] + xi[2] - xi[3];
        sr[3] = xr[0] + xi[1] - xr[2] - xi[3];
        si[3] = xi[0] - xr[1] - xi[2] + xr[3];

        qft_next = {half_sat(sr[0]), half_sat(si[0]),
                    half_sat(sr[1]), half_sat(si[1]),
                    half_sat(sr[2]), half_sat(si[2]),
                    half_sat(sr[3]), half_sat(si[3])};
    end

    always_comb begin
        // samp_sel = 1 reads the registered QFT result, adding a cycle.
        samp_src = samp_sel ? qft_state_out : samp_state_in;

        for (int n = 0; n < 4; n++) begin
            mr[n]     = amp_re(amp(samp_src, n));
            mi[n]     = amp_im(amp(samp_src, n));
            rr[n]     = 16'(mr[n]) * 16'(mr[n]);
            ii[n]     = 16'(mi[n]) * 16'(mi[n]);
            msum[n]   = {1'b0, rr[n]} + {1'b0, ii[n]};
            mshift[n] = msum[n] >> FX_BITS;
            m[n]      = sat8($signed({1'b0, mshift[n]}));
        end

        mag_next = {m[0], m[1], m[2], m[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_x_out     <= '0;
            qft_state_out <= '0;
            mag_sq_out    <= '0;
            out_valid     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                exp_x_out     <= exp_y;
                qft_state_out <= qft_next;
                mag_sq_out    <= mag_next;
            end
        end
    end

endmodule

// File: tb/tb_qft_sampler_core.sv
// Self-checking bench for qft_sampler_core: directed vectors plus random traffic.
// Expected values come from an integer complex-arithmetic reference model.
module tb_qft_sampler_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  exp_x_in;
    logic [63:0] q_state_in;
    logic        samp_sel;
    logic [63:0] samp_state_in;
    logic [7:0]  exp_x_out;
    logic [63:0] qft_state_out;
    logic [31:0] mag_sq_out;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    localparam int KN [9] = '{4, 7, 12, 19, 32, 53, 87, 143, 236};

    logic [7:0]  ref_exp;
    logic [63:0] ref_qft;
    logic [31:0] ref_mag;
    logic        ref_vld;

    qft_sampler_core dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .exp_x_in      (exp_x_in),
        .q_state_in    (q_state_in),
        .samp_sel      (samp_sel),
        .samp_state_in (samp_state_in),
        .exp_x_out     (exp_x_out),
        .qft_state_out (qft_state_out),
        .mag_sq_out    (mag_sq_out),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic int clamp(int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int get_re(logic [63:0] v, int n);
        logic [63:0]       t;
        logic signed [7:0] b;
        t = v >> (16 * (3 - n));
        b = t[15:8];
        return int'(b);
    endfunction

    function automatic int get_im(logic [63:0] v, int n);
        logic [63:0]       t;
        logic signed [7:0] b;
        t = v >> (16 * (3 - n));
        b = t[7:0];
        return int'(b);
    endfunction

    function automatic logic [7:0] m_exp(logic [7:0] xb);
        int x, u, k, off, y;
        x = int'($signed(xb));
        if (x < -64) return 8'd0;
        if (x > 63) return 8'd127;
        u   = x + 64;
        k   = u / 16;
        off = u % 16;
        y   = KN[k] + ((KN[k+1] - KN[k]) * off) / 16;
        return 8'(clamp(y));
    endfunction

    function automatic logic [63:0] m_qft(logic [63:0] v);
        logic [63:0] o;
        int ar, ai, r, i;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            ar = 0;
            ai = 0;
            for (int j = 0; j < 4; j++) begin
                r = get_re(v, j);
                i = get_im(v, j);
                case ((j * k) % 4)
                    0: begin ar += r; ai += i; end
                    1: begin ar -= i; ai += r; end
                    2: begin ar -= r; ai -= i; end
                    default: begin ar += i; ai -= r; end
                endcase
            end
            o = (o << 16) | 64'({8'(clamp(ar >>> 1)), 8'(clamp(ai >>> 1))});
        end
        return o;
    endfunction

    function automatic logic [31:0] m_mag(logic [63:0] v);
        logic [31:0] o;
        int r, i, p;
        o = '0;
        for (int n = 0; n < 4; n++) begin
            r = get_re(v, n);
            i = get_im(v, n);
            p = (r * r + i * i) / 32;
            if (p > 127) p = 127;
            o = (o << 8) | 32'(p);
        end
        return o;
    endfunction

    task automatic tick(string tag);
        logic [7:0]  n_exp;
        logic [63:0] n_qft;
        logic [31:0] n_mag;
        logic        n_vld;
        n_exp = ref_exp;
        n_qft = ref_qft;
        n_mag = ref_mag;
        n_vld = in_valid;
        if (rst) begin
            n_exp = '0;
            n_qft = '0;
            n_mag = '0;
            n_vld = 1'b0;
        end else if (in_valid) begin
            n_exp = m_exp(exp_x_in);
            n_qft = m_qft(q_state_in);
            n_mag = m_mag(samp_sel ? ref_qft : samp_state_in);
        end
        @(posedge clk);
        #1;
        ref_exp = n_exp;
        ref_qft = n_qft;
        ref_mag = n_mag;
        ref_vld = n_vld;
        chk({tag, ".exp"}, 64'(exp_x_out), 64'(ref_exp));
        chk({tag, ".qft"}, qft_state_out, ref_qft);
        chk({tag, ".mag"}, 64'(mag_sq_out), 64'(ref_mag));
        chk({tag, ".vld"}, 64'(out_valid), 64'(ref_vld));
    endtask

    localparam int NX = 7;
    logic [7:0] dx   [NX] = '{8'd0, 8'd23, 8'd32, 8'hE0, 8'd64, 8'd127, 8'h9C};
    logic [7:0] dexp [NX] = '{8'd32, 8'd67, 8'd87, 8'd12, 8'd127, 8'd127, 8'd0};

    initial begin
        ref_exp = '0;
        ref_qft = '0;
        ref_mag = '0;
        ref_vld = 1'b0;

        rst           = 1'b1;
        in_valid      = 1'b0;
        exp_x_in      = '0;
        q_state_in    = '0;
        samp_sel      = 1'b0;
        samp_state_in = '0;
        tick("reset");
        chk("reset.all", {exp_x_out, 24'd0, 31'd0, out_valid}, 64'd0);
        chk("reset.qft", qft_state_out, 64'd0);

        rst      = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < NX; n++) begin
            exp_x_in = dx[n];
            tick("dexp");
            chk("exp.const", 64'(exp_x_out), 64'(dexp[n]));
        end

        q_state_in = 64'h2000_0000_0000_0000;
        tick("q00");
        chk("q00.const", qft_state_out, 64'h1000_1000_1000_1000);

        q_state_in = 64'h0000_2000_0000_0000;
        tick("q01");
        chk("q01.const", qft_state_out, 64'h1000_0010_F000_00F0);
        chk("q01.vld", 64'(out_valid), 64'd1);

        samp_sel = 1'b1;
        tick("sel1");
        chk("sel1.const", 64'(mag_sq_out), 64'h0808_0808);

        in_valid = 1'b0;
        tick("idle");
        chk("idle.vld", 64'(out_valid), 64'd0);
        chk("idle.hold", 64'(mag_sq_out), 64'h0808_0808);

        in_valid      = 1'b1;
        samp_sel      = 1'b0;
        samp_state_in = 64'h1600_0000_1600_0000;
        tick("s22");
        chk("s22.const", 64'(mag_sq_out), 64'h0F00_0F00);

        samp_state_in = 64'h7F7F_7F7F_7F7F_7F7F;
        tick("s127");
        chk("s127.const", 64'(mag_sq_out), 64'h7F7F_7F7F);

        rst = 1'b1;
        tick("midrst");
        chk("midrst.mag", 64'(mag_sq_out), 64'd0);
        chk("midrst.exp", 64'(exp_x_out), 64'd0);

        rst      = 1'b0;
        in_valid = 1'b0;
        tick("posthold");
        chk("posthold.qft", qft_state_out, 64'd0);

        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 31) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            samp_sel      = 1'($urandom_range(0, 1));
            exp_x_in      = 8'($urandom);
            q_state_in    = {$urandom, $urandom};
            samp_state_in = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
                q_state_in = {8{8'h80}};
            if ($urandom_range(0, 7) == 0)
                samp_state_in = {8{8'h80}};
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
